// File: rtl/ws2812_stream_tx.sv
// WS2812/SK6812 single-wire LED driver: valid/ready pixel stream in, MSB-first bit cells out,
// N_LEDS pixels per frame followed by a latch gap. Define WS2812_DIM_EN to add the 3-bit dim input.
module ws2812_stream_tx #(
    parameter int N_LEDS     = 40,
    parameter int COLOR_BITS = 24,
    parameter int BIT_CYC    = 125,
    parameter int T0H_CYC    = 35,
    parameter int T1H_CYC    = 90,
    parameter int RST_CYC    = 6000
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [COLOR_BITS-1:0] pix_data,
    input  logic                  pix_valid,
`ifdef WS2812_DIM_EN
    input  logic [2:0]            dim,
`endif
    output logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun,
    output logic                  sdo
);

    localparam int LED_W  = $clog2(N_LEDS) + 1;
    localparam int CELL_W = $clog2(BIT_CYC) + 1;
    localparam int BITI_W = $clog2(COLOR_BITS) + 1;
    localparam int RST_W  = $clog2(RST_CYC) + 1;

    localparam logic [LED_W-1:0]  LED_N     = LED_W'(N_LEDS);
    localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(BIT_CYC - 1);
    localparam logic [CELL_W-1:0] T0H_C     = CELL_W'(T0H_CYC);
    localparam logic [CELL_W-1:0] T1H_C     = CELL_W'(T1H_CYC);
    localparam logic [BITI_W-1:0] BIT_LAST  = BITI_W'(COLOR_BITS - 1);
    localparam logic [RST_W-1:0]  LAT_LAST  = RST_W'(RST_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_FIRST, S_SHIFT, S_LATCH} state_t;

    state_t                state_q, state_d;
    logic [CELL_W-1:0]     cell_q, cell_d;
    logic [BITI_W-1:0]     bit_q, bit_d;
    logic [COLOR_BITS-1:0] shreg_q, shreg_d;
    logic [COLOR_BITS-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [LED_W-1:0]      acc_q, acc_d;
    logic [LED_W-1:0]      sent_q, sent_d;
    logic [RST_W-1:0]      lat_q, lat_d;
    logic                  req_q, req_d;
    logic                  sdo_q, sdo_d;
    logic                  accept;
    logic                  cell_end;
    logic [COLOR_BITS-1:0] pix_in;

`ifdef WS2812_DIM_EN
    // Each colour component is dimmed independently as it is captured.
    genvar gi;
    generate
        for (gi = 0; gi < COLOR_BITS / 8; gi++) begin : g_dim
            assign pix_in[8*gi +: 8] = pix_data[8*gi +: 8] >> dim;
        end
    endgenerate
`else
    assign pix_in = pix_data;
`endif

    assign pix_ready = ((state_q == S_WAIT_FIRST) || (state_q == S_SHIFT))
                       && !hold_full_q && (acc_q < LED_N);
    assign accept    = pix_valid && pix_ready;
    assign cell_end  = (cell_q == CELL_LAST);
    assign busy      = (state_q != S_IDLE);
    assign sdo       = sdo_q;

    always_comb begin
        state_d     = state_q;
        cell_d      = cell_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        acc_d       = accept ? acc_q + 1'b1 : acc_q;
        sent_d      = sent_q;
        lat_d       = lat_q;
        req_d       = req_q;
        underrun    = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_WAIT_FIRST;
                    req_d       = 1'b1;
                    acc_d       = '0;
                    sent_d      = '0;
                    hold_full_d = 1'b0;
                end
            end
            S_WAIT_FIRST: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    shreg_d = pix_in;
                    sent_d  = sent_q + 1'b1;
                    cell_d  = '0;
                    bit_d   = '0;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    hold_d      = pix_in;
                    hold_full_d = 1'b1;
                end
                if (!cell_end) begin
                    cell_d = cell_q + 1'b1;
                end else begin
                    cell_d = '0;
                    if (bit_q != BIT_LAST) begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end else if (sent_q == LED_N) begin
                        state_d = S_LATCH;
                        lat_d   = '0;
                    end else if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_d       = '0;
                        sent_d      = sent_q + 1'b1;
                    end else if (accept) begin
                        // Pixel arriving exactly on the boundary goes straight to the shifter.
                        shreg_d     = pix_in;
                        hold_full_d = 1'b0;
                        bit_d       = '0;
                        sent_d      = sent_q + 1'b1;
                    end else begin
                        underrun = 1'b1;
                        state_d  = S_LATCH;
                        lat_d    = '0;
                    end
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    frame_done = req_q;
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = S_LATCH;
        endcase

        sdo_d = (state_d == S_SHIFT)
                && (cell_d < (shreg_d[COLOR_BITS-1] ? T1H_C : T0H_C));
    end

    // Reset lands in LATCH so a chain interrupted mid-frame is latched cleanly.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= S_LATCH;
            cell_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            acc_q       <= '0;
            sent_q      <= '0;
            lat_q       <= '0;
            req_q       <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cell_q      <= cell_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            acc_q       <= acc_d;
            sent_q      <= sent_d;
            lat_q       <= lat_d;
            req_q       <= req_d;
            sdo_q       <= sdo_d;
        end
    end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Scoreboard bench for ws2812_stream_tx (N_LEDS=2, default timing): stimulus queues expected
// bit cells and event cycles, a negedge monitor decodes sdo/frame_done/underrun against them.
module tb_ws2812_stream_tx;

    localparam int NL = 2;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, busy, frame_done, underrun, sdo;
`ifdef WS2812_DIM_EN
    logic [2:0]  dim = 3'd0;
`endif

    ws2812_stream_tx #(.N_LEDS(NL)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
`ifdef WS2812_DIM_EN
        .dim         (dim),
`endif
        .pix_ready   (pix_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .sdo         (sdo)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int len;
    } bit_exp_t;

    bit_exp_t exp_bits[$];
    int       fd_q[$];
    int       ur_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    int       frame_base = 0;
    int       last_acc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sysclk);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
    endtask

    // Present px until accepted; queue the 24 expected cells of exp_px as pixel j of the frame.
    task automatic offer(input logic [23:0] px, input logic [23:0] exp_px, input int j);
        int t;
        bit_exp_t e;
        t = 0;
        pix_data  = px;
        pix_valid = 1'b1;
        while (!pix_ready && t < 200) begin
            @(negedge sysclk);
            t++;
        end
        if (!pix_ready) begin
            flag("accept_timeout");
        end else begin
            last_acc = cyc;
            if (j == 0) frame_base = cyc + 1;
            for (int i = 0; i < 24; i++) begin
                e.rise = frame_base + 125 * (24 * j + i);
                e.len  = exp_px[23 - i] ? 90 : 35;
                exp_bits.push_back(e);
            end
            $display("tb: pixel %06h accepted at cycle %0d (slot %0d)", px, cyc, j);
        end
        @(negedge sysclk);
        pix_valid = 1'b0;
    endtask

    // Monitor: decodes sdo pulses and checks event pulses against the queues.
    initial begin : monitor
        logic     prev_sdo;
        logic     in_pulse;
        int       hi_cnt;
        int       cur_len;
        bit_exp_t e;
        prev_sdo = 1'b0;
        in_pulse = 1'b0;
        hi_cnt   = 0;
        cur_len  = 0;
        forever begin
            @(negedge sysclk);
            if (rst) begin
                prev_sdo = 1'b0;
                in_pulse = 1'b0;
            end else begin
                if (sdo && !prev_sdo) begin
                    if (exp_bits.size() == 0) begin
                        flag("sdo_rise_unexpected");
                    end else begin
                        e = exp_bits.pop_front();
                        chk("bit_rise_cycle", cyc, e.rise);
                        cur_len  = e.len;
                        hi_cnt   = 1;
                        in_pulse = 1'b1;
                    end
                end else if (sdo && in_pulse) begin
                    hi_cnt++;
                end else if (!sdo && prev_sdo && in_pulse) begin
                    chk("bit_high_len", hi_cnt, cur_len);
                    in_pulse = 1'b0;
                end
                if (frame_done) begin
                    $display("tb: frame_done at cycle %0d", cyc);
                    if (fd_q.size() == 0) flag("frame_done_unexpected");
                    else chk("frame_done_cycle", cyc, fd_q.pop_front());
                end
                if (underrun) begin
                    $display("tb: underrun at cycle %0d", cyc);
                    if (ur_q.size() == 0) flag("underrun_unexpected");
                    else chk("underrun_cycle", cyc, ur_q.pop_front());
                end
                prev_sdo = sdo;
            end
        end
    end

    task automatic check_drained(input string tag);
        chk({tag, "_bits_pending"}, exp_bits.size(), 0);
        chk({tag, "_fd_pending"}, fd_q.size(), 0);
        chk({tag, "_ur_pending"}, ur_q.size(), 0);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        int k0;
        int seen;
        int fd;

        // Reset values and power-on latch with an ignored frame_start.
        repeat (3) @(negedge sysclk);
        chk("rst_sdo", int'(sdo), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        c = cyc;
        wait_until(c + 100);
        pulse_start();
        wait_until(c + 5999);
        chk("por_busy_last_latch", int'(busy), 1);
        wait_until(c + 6000);
        chk("por_busy_idle", int'(busy), 0);
        wait_until(c + 6003);
        chk("por_start_ignored", int'(busy), 0);

        // Full frame of two pixels with pix_valid kept high; frame_start hits in SHIFT and LATCH.
        pulse_start();
        offer(24'h800001, 24'h800001, 0);
        k0 = last_acc;
        offer(24'hA5C33C, 24'hA5C33C, 1);
        chk("second_accept_cycle", last_acc, k0 + 1);
        fd = frame_base + 2 * 3000 + 5999;
        fd_q.push_back(fd);
        pix_data  = 24'h5A5A5A;
        pix_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 3500; i++) begin
            @(negedge sysclk);
            if (pix_ready) seen++;
            if (i == 500) frame_start = 1'b1;
            else frame_start = 1'b0;
        end
        pix_valid = 1'b0;
        chk("ready_low_after_last", seen, 0);
        wait_until(fd - 3000);
        pulse_start();
        wait_until(fd + 20);
        chk("frame_a_idle", int'(busy), 0);
        check_drained("frame_a");

        // Underrun: second pixel withheld.
        pulse_start();
        offer(24'h0F00FF, 24'h0F00FF, 0);
        ur_q.push_back(last_acc + 3000);
        fd_q.push_back(last_acc + 9000);
        chk("ready_with_hold_empty", int'(pix_ready), 1);
        wait_until(last_acc + 3001);
        chk("busy_in_underrun_latch", int'(busy), 1);
        wait_until(last_acc + 9020);
        chk("underrun_idle", int'(busy), 0);
        check_drained("underrun");

        // Reset mid-cell while sdo is high.
        pulse_start();
        offer(24'hFFFFFF, 24'hFFFFFF, 0);
        offer(24'h123456, 24'h123456, 1);
        wait_until(frame_base + 125 * 3 + 10);
        chk("sdo_high_before_rst", int'(sdo), 1);
        rst = 1'b1;
        @(negedge sysclk);
        chk("midrst_sdo", int'(sdo), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        exp_bits.delete();
        fd_q.delete();
        @(negedge sysclk);
        rst = 1'b0;
        c = cyc;
        wait_until(c + 50);
        pulse_start();
        wait_until(c + 5999);
        chk("midrst_busy_last_latch", int'(busy), 1);
        wait_until(c + 6000);
        chk("midrst_busy_idle", int'(busy), 0);
        wait_until(c + 6010);
        chk("midrst_start_ignored", int'(busy), 0);
        check_drained("midrst");

`ifdef WS2812_DIM_EN
        // Dimmed frame: each component shifted right by one.
        dim = 3'd1;
        pulse_start();
        offer(24'hFF8002, 24'h7F4001, 0);
        offer(24'h030201, 24'h010100, 1);
        dim = 3'd0;
        fd_q.push_back(frame_base + 2 * 3000 + 5999);
        wait_until(frame_base + 2 * 3000 + 6020);
        check_drained("dim");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_stream_tx.md
Name: ws2812_stream_tx

Overview:
Parametrised WS2812/SK6812 serial LED driver.
- Accepts pixels from a valid/ready stream and serialises them MSB-first onto a single-wire output using configurable bit-cell timing.
- Sends exactly N_LEDS pixels per frame, then applies the latch (reset) low gap.
- Sits between a pixel source (pattern generator, frame buffer reader) and a Pmod/header pin on the board top level.

Parameters:
N_LEDS, 40, pixels per frame (1..4095)
COLOR_BITS, 24, bits per pixel; 24 for GRB, 32 for GRBW; must be a multiple of 8
BIT_CYC, 125, sysclk cycles per bit cell (1.25 us at 100 MHz)
T0H_CYC, 35, high cycles for a 0 bit
T1H_CYC, 90, high cycles for a 1 bit; requires 0 < T0H_CYC < T1H_CYC < BIT_CYC
RST_CYC, 6000, low cycles for the latch gap (>= 50 us)

Ports:
sysclk  in  1  clock, 100 MHz nominal
rst  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle request to start a frame; sampled only in IDLE
pix_data  in  COLOR_BITS  pixel, wire order (G first), MSB sent first
pix_valid  in  1  pix_data valid
pix_ready  out  1  block accepts pix_data this cycle
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at the end of the latch gap of a requested frame
underrun  out  1  one-cycle pulse when the frame is aborted for lack of data
sdo  out  1  serial data to the LED chain (registered)

Behaviour:
- Reset is synchronous, active-high, clock sysclk.
- During rst: sdo=0, pix_ready=0, frame_done=0, underrun=0, holding register empty, counters cleared.
- After rst deasserts, the block enters LATCH, with busy=1 and sdo=0 for RST_CYC cycles, so a truncated chain is latched cleanly. It then goes to IDLE. No frame_done pulse is produced for this power-on latch.
- Reset mid-frame: sdo falls on the next edge, the frame is abandoned, and the post-reset LATCH applies.
- States: IDLE, WAIT_FIRST, SHIFT, LATCH.
- IDLE: sdo=0, busy=0. frame_start=1 moves to WAIT_FIRST.
- WAIT_FIRST: sdo=0. The block waits indefinitely for the first pixel; no underrun is possible here. An accept moves to SHIFT.
- SHIFT, bit-cell timing:
  - Cell counter runs 0..BIT_CYC-1.
  - sdo=1 while the counter < (bit ? T1H_CYC : T0H_CYC), else sdo=0.
  - The first cell starts so that sdo is high in the cycle after the accepting edge.
  - Cells are back-to-back with no idle gap between bits or between pixels.
- Holding register: one entry.
  - pix_ready = (state is WAIT_FIRST or SHIFT) and holding register empty and accepted count < N_LEDS.
  - Accept = pix_valid & pix_ready. pix_data is stable-capture only on accept.
- Pixel boundary: at the last cycle of the last bit cell of a pixel:
  - If pixels sent < N_LEDS and the holding register is full: load the shift register from the holding register and continue with no gap.
  - If pixels sent < N_LEDS and the holding register is empty: pulse underrun, force sdo=0, and enter LATCH. frame_done still pulses at the end of that LATCH.
  - If pixels sent == N_LEDS: enter LATCH.
- Simultaneous accept and pixel-boundary load in the same cycle: the holding register is loaded, and the just-accepted pixel becomes the next pixel. Pixel order is never reordered.
- LATCH: sdo=0 for exactly RST_CYC cycles. frame_done pulses in the last LATCH cycle. Transition to IDLE follows.
- frame_start while busy is ignored, with no queuing.
- Counter widths: $clog2 of the respective maximum plus 1. No wrap-around is possible within range.

Optional Feature:
Macro WS2812_DIM_EN.
- Defined: adds port dim (in, 3 bits). Each 8-bit component of the pixel is logically right-shifted by dim at holding-register load. dim is sampled on accept.
- Undefined: no dim port; pixels are transmitted unmodified.

Test Plan:
1. N_LEDS=1: frame_start, then pixel 0x800001 accepted at cycle k → sdo high cycles k+1..k+90, low 35 cycles; the next 22 cells are 35 high / 90 low; the last cell is 90 high / 35 low. Then 6000 low cycles, and frame_done pulses at cycle k+3000+6000.
2. N_LEDS=3 with pix_valid held high: three pixels accepted, with sdo edges continuous across pixel boundaries (exactly 125-cycle cells, 72 cells total). pix_ready stays low after the third accept.
3. Underrun: N_LEDS=2, second pixel withheld → underrun pulses at the end of cell 24, sdo stays 0 for 6000 cycles, then frame_done pulses.
4. rst asserted mid-cell with sdo=1 → sdo=0 on the next edge; after release, busy=1 for 6000 cycles and no frame_done pulse; frame_start during that window is ignored.
5. frame_start pulsed during SHIFT and LATCH → exactly one frame transmitted and one frame_done pulse.
6. WS2812_DIM_EN, dim=1, pixel 0xFF8002 → wire bits 0x7F4001.
